// File: rtl/barrido_display.sv
// Six-digit scan controller for the signed Booth multiplier result: double-buffered BCD/sign, guarded slots, active-low drive.
// Optional leading-zero blanking is enabled by defining BARRIDO_SUPRIME_CEROS_EN.
module barrido_display #(
  parameter int CICLOS_DIGITO = 100000,
  parameter int CICLOS_GUARDA = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [19:0] dato_bcd,
  input  logic        signo,
  input  logic        dato_valido,
  output logic        dato_listo,
  output logic [7:0]  anodo,
  output logic [6:0]  segmentos,
  output logic        fin_trama
);

  localparam int CW = (CICLOS_DIGITO > 1) ? $clog2(CICLOS_DIGITO) : 1;
  localparam logic [CW-1:0] CNT_FIN_GUARDA = CW'(CICLOS_GUARDA - 1);
  localparam logic [CW-1:0] CNT_FIN_SLOT   = CW'(CICLOS_DIGITO - 1);
  localparam logic [2:0]    IDX_SIGNO      = 3'd5;
  localparam logic [6:0]    SEG_BLANCO     = 7'h7F;
  localparam logic [6:0]    SEG_MENOS      = 7'b0111111;

  typedef enum logic {GUARDA, ENCENDIDO} estado_t;

  estado_t        state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2:0]     idx_q, idx_d;
  logic [19:0]    disp_bcd_q, disp_bcd_d;
  logic           disp_signo_q, disp_signo_d;
  logic [19:0]    pend_bcd_q, pend_bcd_d;
  logic           pend_signo_q, pend_signo_d;
  logic           pendiente_q, pendiente_d;
  logic [7:0]     anodo_q, anodo_d;
  logic [6:0]     segmentos_q, segmentos_d;
  logic           fin_trama_q, fin_trama_d;
  logic           acepta;
  logic [4:0]     blanco;

  function automatic logic [6:0] seg_codigo(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANCO;
    endcase
    return s;
  endfunction

  assign acepta = dato_valido && !pendiente_q;

  // Slot timing: counter, index and guard/on state.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CW'(1);
    idx_d       = idx_q;
    case (state_q)
      GUARDA: begin
        if (cnt_q == CNT_FIN_GUARDA) state_d = ENCENDIDO;
      end
      ENCENDIDO: begin
        if (cnt_q == CNT_FIN_SLOT) begin
          state_d = GUARDA;
          cnt_d   = '0;
          idx_d   = (idx_q == IDX_SIGNO) ? 3'd0 : idx_q + 3'd1;
        end
      end
      default: state_d = GUARDA;
    endcase
    fin_trama_d = (idx_d == IDX_SIGNO) && (cnt_d == CNT_FIN_SLOT);
  end

  // Buffering: the display register only changes on the fin_trama cycle.
  always_comb begin
    disp_bcd_d   = disp_bcd_q;
    disp_signo_d = disp_signo_q;
    pend_bcd_d   = pend_bcd_q;
    pend_signo_d = pend_signo_q;
    pendiente_d  = pendiente_q;
    if (fin_trama_q && pendiente_q) begin
      disp_bcd_d   = pend_bcd_q;
      disp_signo_d = pend_signo_q;
      pendiente_d  = 1'b0;
    end else if (fin_trama_q && acepta) begin
      disp_bcd_d   = dato_bcd;
      disp_signo_d = signo;
    end else if (acepta) begin
      pend_bcd_d   = dato_bcd;
      pend_signo_d = signo;
      pendiente_d  = 1'b1;
    end
  end

  always_comb begin
    blanco = '0;
`ifdef BARRIDO_SUPRIME_CEROS_EN
    blanco[4] = (disp_bcd_d[19:16] == 4'd0);
    blanco[3] = blanco[4] && (disp_bcd_d[15:12] == 4'd0);
    blanco[2] = blanco[3] && (disp_bcd_d[11:8] == 4'd0);
    blanco[1] = blanco[2] && (disp_bcd_d[7:4] == 4'd0);
`else
    blanco = '0;
`endif
  end

  // Outputs are computed from next-cycle values so the registered drive matches the slot.
  always_comb begin
    anodo_d     = 8'hFF;
    segmentos_d = SEG_BLANCO;
    if (state_d == ENCENDIDO) begin
      anodo_d = ~(8'h01 << idx_d);
      case (idx_d)
        3'd0: segmentos_d = blanco[0] ? SEG_BLANCO : seg_codigo(disp_bcd_d[3:0]);
        3'd1: segmentos_d = blanco[1] ? SEG_BLANCO : seg_codigo(disp_bcd_d[7:4]);
        3'd2: segmentos_d = blanco[2] ? SEG_BLANCO : seg_codigo(disp_bcd_d[11:8]);
        3'd3: segmentos_d = blanco[3] ? SEG_BLANCO : seg_codigo(disp_bcd_d[15:12]);
        3'd4: segmentos_d = blanco[4] ? SEG_BLANCO : seg_codigo(disp_bcd_d[19:16]);
        3'd5: segmentos_d = disp_signo_d ? SEG_MENOS : SEG_BLANCO;
        default: segmentos_d = SEG_BLANCO;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= GUARDA;
      cnt_q        <= '0;
      idx_q        <= '0;
      disp_bcd_q   <= '0;
      disp_signo_q <= 1'b0;
      pend_bcd_q   <= '0;
      pend_signo_q <= 1'b0;
      pendiente_q  <= 1'b0;
      anodo_q      <= 8'hFF;
      segmentos_q  <= SEG_BLANCO;
      fin_trama_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      disp_bcd_q   <= disp_bcd_d;
      disp_signo_q <= disp_signo_d;
      pend_bcd_q   <= pend_bcd_d;
      pend_signo_q <= pend_signo_d;
      pendiente_q  <= pendiente_d;
      anodo_q      <= anodo_d;
      segmentos_q  <= segmentos_d;
      fin_trama_q  <= fin_trama_d;
    end
  end

  assign anodo      = anodo_q;
  assign segmentos  = segmentos_q;
  assign fin_trama  = fin_trama_q;
  assign dato_listo = ~pendiente_q;

endmodule

// File: tb/tb_barrido_display.sv
// Bench for barrido_display: accepted values queue up and are popped at frame boundaries to form the expected display.
// Expected blanking follows BARRIDO_SUPRIME_CEROS_EN when that macro is defined for the build.
module tb_barrido_display;

  localparam int CD    = 8;
  localparam int CG    = 2;
  localparam int TRAMA = 6 * CD;

  typedef struct packed {
    logic [19:0] bcd;
    logic        signo;
  } dato_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [19:0] dato_bcd = '0;
  logic        signo = 1'b0;
  logic        dato_valido = 1'b0;
  logic        dato_listo;
  logic [7:0]  anodo;
  logic [6:0]  segmentos;
  logic        fin_trama;

  int          vectors = 0;
  int          miscompares = 0;
  int          pos = 0;
  dato_t       q[$];
  logic [19:0] exp_bcd = '0;
  logic        exp_signo = 1'b0;

  barrido_display #(.CICLOS_DIGITO(CD), .CICLOS_GUARDA(CG)) dut (
    .clk(clk), .rst_n(rst_n), .dato_bcd(dato_bcd), .signo(signo),
    .dato_valido(dato_valido), .dato_listo(dato_listo), .anodo(anodo),
    .segmentos(segmentos), .fin_trama(fin_trama)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg_ref(input logic [3:0] v);
    case (v)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [6:0] exp_slot(input int slot);
    logic [3:0] nib;
    if (slot == 5) return exp_signo ? 7'b0111111 : 7'h7F;
    nib = exp_bcd[slot*4 +: 4];
`ifdef BARRIDO_SUPRIME_CEROS_EN
    if (slot > 0 && (exp_bcd >> (slot * 4)) == 20'd0) return 7'h7F;
`endif
    return seg_ref(nib);
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Checks the current cycle against the frame model, then advances one clock.
  task automatic cycle();
    int         slot;
    int         c;
    logic [7:0] e_an;
    logic [6:0] e_seg;
    slot  = pos / CD;
    c     = pos % CD;
    e_an  = (c < CG) ? 8'hFF : ~(8'h01 << slot);
    e_seg = (c < CG) ? 7'h7F : exp_slot(slot);
    chk($sformatf("anodo@%0d", pos), anodo, e_an);
    chk($sformatf("segmentos@%0d", pos), {1'b0, segmentos}, {1'b0, e_seg});
    chk($sformatf("fin_trama@%0d", pos), {7'b0, fin_trama}, {7'b0, pos == TRAMA - 1});
    chk($sformatf("dato_listo@%0d", pos), {7'b0, dato_listo}, {7'b0, q.size() == 0});
    if (dato_valido && q.size() == 0) q.push_back('{bcd: dato_bcd, signo: signo});
    if (pos == TRAMA - 1 && q.size() > 0) begin
      dato_t d;
      d = q.pop_front();
      exp_bcd   = d.bcd;
      exp_signo = d.signo;
    end
    @(posedge clk);
    @(negedge clk);
    pos = (pos + 1) % TRAMA;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic run_to(input int target);
    for (int i = 0; i < TRAMA && pos != target; i++) cycle();
  endtask

  // Holds valido until the DUT reports listo, then completes the transfer cycle.
  task automatic offer(input logic [19:0] bcd, input logic sgn);
    int n;
    dato_bcd    = bcd;
    signo       = sgn;
    dato_valido = 1'b1;
    n = 0;
    while (dato_listo !== 1'b1 && n < 2 * TRAMA) begin
      cycle();
      n++;
    end
    chk("offer_wait_listo", {7'b0, dato_listo}, 8'h01);
    cycle();
    dato_valido = 1'b0;
  endtask

  task automatic do_reset(input int edges);
    rst_n       = 1'b0;
    dato_valido = 1'b0;
    repeat (edges) @(posedge clk);
    @(negedge clk);
    chk("reset_anodo", anodo, 8'hFF);
    chk("reset_segmentos", {1'b0, segmentos}, 8'h7F);
    chk("reset_fin_trama", {7'b0, fin_trama}, 8'h00);
    chk("reset_dato_listo", {7'b0, dato_listo}, 8'h01);
    rst_n     = 1'b1;
    pos       = 0;
    q.delete();
    exp_bcd   = '0;
    exp_signo = 1'b0;
  endtask

  initial begin
    // Idle frame after reset.
    do_reset(2);
    run(TRAMA);

    // Accept at cycle 10; visible from the next frame.
    run(10);
    offer(20'h12345, 1'b1);
    run_to(0);
    run(TRAMA);

    // Back-to-back offers: the second waits for the frame boundary.
    run(5);
    offer(20'h67890, 1'b0);
    offer(20'h00450, 1'b1);
    run_to(0);
    run(TRAMA);

    // Leading zeros and invalid BCD codes.
    run(3);
    offer(20'h00007, 1'b0);
    run_to(0);
    run(TRAMA);
    offer(20'h0C0B9, 1'b1);
    run_to(0);
    run(TRAMA);

    // Accept in the fin_trama cycle.
    run_to(TRAMA - 1);
    offer(20'h54321, 1'b0);
    run(TRAMA);

    // Reset in slot 3 with data pending.
    run_to(20);
    offer(20'h11111, 1'b1);
    run_to(26);
    chk("pending_before_reset", {7'b0, dato_listo}, 8'h00);
    do_reset(1);
    run(TRAMA);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
